// File: rtl/sys_ctrl.sv
// sys_ctrl: UART command decoder driving a register file and returning read data as two bytes.
// Ports: CLK/RST (async active-low) | RX_P_Data, RX_D_VLD: received bytes |
//        RdData: register-file read data | TX_Busy: transmitter busy |
//        WrEn, RdEn, Address, WrData: register-file strobes/bus |
//        TX_P_Data, TX_D_VLD: byte offered to the transmitter | CMD_ERR: unknown-opcode pulse.
module sys_ctrl #(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 4,
  parameter logic [7:0]  WR_CMD     = 8'hAA,
  parameter logic [7:0]  RD_CMD     = 8'hBB
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_Data,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  TX_Busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [7:0]            TX_P_Data,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC, RD_ADDR, RD_EXEC, RD_CAPT,
    TX_LO, TX_LO_WAIT, TX_HI, TX_HI_WAIT
  } state_t;
  state_t r_state, w_state_nx;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic w_tx;
  assign w_tx = (r_state == TX_LO) || (r_state == TX_HI);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nx;
  // TX_D_VLD is itself a register, so "byte accepted" is VLD seen together with Busy.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:       if (RX_D_VLD) w_state_nx = (RX_P_Data == WR_CMD) ? WR_ADDR :
                                             (RX_P_Data == RD_CMD) ? RD_ADDR : IDLE;
      WR_ADDR:    if (RX_D_VLD) w_state_nx = WR_DLO;
      WR_DLO:     if (RX_D_VLD) w_state_nx = WR_DHI;
      WR_DHI:     if (RX_D_VLD) w_state_nx = WR_EXEC;
      WR_EXEC:    w_state_nx = IDLE;
      RD_ADDR:    if (RX_D_VLD) w_state_nx = RD_EXEC;
      RD_EXEC:    w_state_nx = RD_CAPT;
      RD_CAPT:    w_state_nx = TX_LO;
      TX_LO:      if (TX_D_VLD && TX_Busy) w_state_nx = TX_LO_WAIT;
      TX_LO_WAIT: if (!TX_Busy) w_state_nx = TX_HI;
      TX_HI:      if (TX_D_VLD && TX_Busy) w_state_nx = TX_HI_WAIT;
      TX_HI_WAIT: if (!TX_Busy) w_state_nx = IDLE;
      default:    w_state_nx = IDLE;
    endcase
  end
  // Strobes are registered from the next state so they are high exactly while
  // the FSM sits in WR_EXEC / RD_EXEC; read data then arrives during RD_CAPT.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      CMD_ERR   <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      r_rd_data <= '0;
      TX_P_Data <= '0;
      TX_D_VLD  <= 1'b0;
    end else begin
      WrEn    <= w_state_nx == WR_EXEC;
      RdEn    <= w_state_nx == RD_EXEC;
      CMD_ERR <= (r_state == IDLE) && RX_D_VLD && (w_state_nx == IDLE);
      if (RX_D_VLD && (r_state == WR_ADDR || r_state == RD_ADDR)) Address <= RX_P_Data[ADDR_WIDTH-1:0];
      if (RX_D_VLD && r_state == WR_DLO) WrData[7:0] <= RX_P_Data;
      if (RX_D_VLD && r_state == WR_DHI) WrData[DATA_WIDTH-1 -: 8] <= RX_P_Data;
      if (r_state == RD_CAPT) r_rd_data <= RdData;
      if (w_tx && !TX_D_VLD && !TX_Busy) begin
        TX_D_VLD  <= 1'b1;
        TX_P_Data <= (r_state == TX_LO) ? r_rd_data[7:0] : r_rd_data[DATA_WIDTH-1 -: 8];
      end else if (w_tx && TX_D_VLD && TX_Busy) TX_D_VLD <= 1'b0;
    end
endmodule
